demux_stream_chan: RTL and testbench
====================================

Name: demux_stream_chan

Overview:
- Inverse of the ALU channel multiplexer: takes one WIDTH-bit input stream tagged with a channel select and distributes each word to one of CHANNELS output channels.
- Each channel has a one-entry registered holding slot with a valid/ready handshake.
- All slot contents are presented on a packed output bus (channel i at bits [i*WIDTH +: WIDTH]). The packed bus is directly consumable by the existing mux and by ALU operand collectors.

Parameters:
- WIDTH, 8, data word width in bits
- CHANNELS, 4, number of output channels (>=2)
- SEL_LENGTH, 2, select width; 2^SEL_LENGTH >= CHANNELS
- CNT_WIDTH, 16, width of the accepted-word counter

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- in_data  input  WIDTH  word to distribute
- in_sel  input  SEL_LENGTH  destination channel index
- in_valid  input  1  in_data/in_sel valid
- in_ready  output  1  block accepts the word this cycle
- out_bus  output  CHANNELS*WIDTH  packed slot contents, channel i at [i*WIDTH +: WIDTH]
- out_valid  output  CHANNELS  slot i holds a word
- out_ready  input  CHANNELS  consumer of channel i takes the word this cycle
- err_sel  output  1  sticky flag: a word with in_sel >= CHANNELS was received
- acc_count  output  CNT_WIDTH  count of words accepted into slots, wraps modulo 2^CNT_WIDTH

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: all slots are empty (out_valid = 0) and all slot data = 0, so out_bus = 0. err_sel = 0 and acc_count = 0. Reset overrides any transfer in the same cycle, and a reset mid-stream discards held words.
- Per-slot state: full[i] and data[i]. out_valid[i] = full[i]; out_bus slice i = data[i].
- can_accept[i] = !full[i] || out_ready[i]. This is a combinational path from out_ready to in_ready and is intentional.
- Legal select (in_sel < CHANNELS): in_ready = can_accept[in_sel].
- Illegal select: in_ready = 1. The word is sunk and dropped, err_sel is set on transfer, no slot changes, and acc_count does not increment.
- Transfer occurs when in_valid && in_ready.
  - On a legal transfer to slot s: data[s] <= in_data, full[s] <= 1, and acc_count increments by 1.
- Pop of slot i occurs when full[i] && out_ready[i]. If there is no simultaneous load, full[i] <= 0 and data[i] holds its last value.
- Simultaneous pop and load on the same slot: the slot stays full with the new data. This gives full throughput of one word per cycle into any single channel.
- Pops on other channels are independent and concurrent with a load.
- Latency: a word accepted at edge N is visible on out_bus/out_valid after edge N, i.e. in cycle N+1. There is no bypass.
- in_data and in_sel are don't-care when in_valid = 0. out_ready[i] is ignored when the slot is empty.
- Ordering is per channel and trivially preserved, since each slot is one entry.
- acc_count wraps from 2^CNT_WIDTH-1 to 0.
- err_sel stays set until rst.

Optional Feature:
- Macro: DEMUX_STREAM_BROADCAST_EN
- When defined:
  - Adds input port in_bcast (1 bit).
  - A transfer with in_bcast = 1 writes in_data into every slot.
  - in_ready = AND of can_accept[i] over all channels; in_sel is ignored and err_sel is unaffected.
  - acc_count increments by CHANNELS, with wrap.
- When undefined: port absent; behaviour exactly as above.

Decomposition:
- Shared package demux_stream_pkg:
  - default WIDTH, CHANNELS, SEL_LENGTH and CNT_WIDTH constants
  - slot-state encoding (SLOT_EMPTY = 0, SLOT_FULL = 1)
- Natural sub-module demux_chan_slot: one-entry holding register.
  - Ports: clk, rst, load, load_data, out_ready, full, data, can_accept.
  - Instantiated CHANNELS times by a generate loop.
- The top level keeps select decode, the in_ready mux, the error flag, the counter and the broadcast logic.

Test Plan:
- Reset check: after rst, out_valid = 4'b0000, out_bus = 32'h0, err_sel = 0, acc_count = 0, in_ready = 1 for every in_sel 0..3.
- Routing: send 8'hA5 to sel 2 with out_ready = 0 -> next cycle out_valid = 4'b0100, out_bus[23:16] = 8'hA5, acc_count = 1. A second send to sel 2 sees in_ready = 0 until out_ready[2] = 1.
- Back-to-back: hold out_ready[1] = 1 and stream 8'h01, 8'h02, 8'h03 to sel 1 on consecutive cycles -> in_ready stays 1 throughout, out_bus[15:8] shows 01, 02, 03 on successive cycles, acc_count = 3.
- Concurrency: slot 0 full, pop via out_ready[0] while loading 8'h3C into slot 3 -> out_valid = 4'b1000, out_bus[31:24] = 8'h3C.
- Illegal select: with CHANNELS = 3 and SEL_LENGTH = 2, send sel 3 -> in_ready = 1, word dropped, err_sel = 1 and stays set, acc_count unchanged, no slot modified. A subsequent rst clears err_sel.
- Broadcast (macro defined): in_bcast = 1 with data 8'h7E and all slots empty -> out_valid = 4'b1111, out_bus = 32'h7E7E7E7E, acc_count += 4. With slot 1 full and out_ready[1] = 0 -> in_ready = 0.

Source files
------------

// File: rtl/demux_stream_pkg.sv
// rtl/demux_stream_pkg.sv - shared defaults and slot-state encoding for demux_stream_chan
package demux_stream_pkg;

  localparam int DEF_WIDTH      = 8;
  localparam int DEF_CHANNELS   = 4;
  localparam int DEF_SEL_LENGTH = 2;
  localparam int DEF_CNT_WIDTH  = 16;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_chan_slot.sv
// rtl/demux_chan_slot.sv - one-entry holding register with valid/ready handshake
module demux_chan_slot
  import demux_stream_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             full,
  output logic [WIDTH-1:0] data,
  output logic             can_accept
);

  slot_state_e      r_state;
  logic [WIDTH-1:0] r_data;

  // A load wins over a pop, so a slot popped and refilled in one cycle stays full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SLOT_EMPTY;
      r_data  <= '0;
    end else if (load) begin
      r_state <= SLOT_FULL;
      r_data  <= load_data;
    end else if ((r_state == SLOT_FULL) && out_ready) begin
      r_state <= SLOT_EMPTY;
    end
  end

  assign full       = (r_state == SLOT_FULL);
  assign data       = r_data;
  assign can_accept = !full || out_ready;

endmodule

// File: rtl/demux_stream_chan.sv
// rtl/demux_stream_chan.sv - select-tagged stream demultiplexer (optional DEMUX_STREAM_BROADCAST_EN)
module demux_stream_chan
  import demux_stream_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int SEL_LENGTH = DEF_SEL_LENGTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_LENGTH-1:0]     in_sel,
  input  logic                      in_valid,
`ifdef DEMUX_STREAM_BROADCAST_EN
  input  logic                      in_bcast,
`endif
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_bus,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic                      err_sel,
  output logic [CNT_WIDTH-1:0]      acc_count
);

  logic [CHANNELS-1:0]  w_can_accept;
  logic [CHANNELS-1:0]  w_load;
  logic                 w_sel_legal;
  logic                 w_sel_ready;
  logic                 w_bcast;
  logic                 w_xfer;
  logic [CNT_WIDTH-1:0] w_acc_inc;
  logic [CNT_WIDTH-1:0] r_acc_count;
  logic                 r_err_sel;

`ifdef DEMUX_STREAM_BROADCAST_EN
  assign w_bcast = in_bcast;
`else
  assign w_bcast = 1'b0;
`endif

  // Selects with no matching channel keep the default ready so they are sunk.
  always_comb begin
    w_sel_legal = 1'b0;
    w_sel_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (in_sel == SEL_LENGTH'(i)) begin
        w_sel_legal = 1'b1;
        w_sel_ready = w_can_accept[i];
      end
    end
  end

  assign in_ready = w_bcast ? (&w_can_accept) : w_sel_ready;
  assign w_xfer   = in_valid && in_ready;

  always_comb begin
    w_load = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_load[i] = w_xfer && (w_bcast || (in_sel == SEL_LENGTH'(i)));
    end
  end

  always_comb begin
    w_acc_inc = '0;
    if (w_bcast) begin
      w_acc_inc = CNT_WIDTH'(CHANNELS);
    end else if (w_sel_legal) begin
      w_acc_inc = CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_count <= '0;
      r_err_sel   <= 1'b0;
    end else if (w_xfer) begin
      r_acc_count <= r_acc_count + w_acc_inc;
      if (!w_bcast && !w_sel_legal) begin
        r_err_sel <= 1'b1;
      end
    end
  end

  assign acc_count = r_acc_count;
  assign err_sel   = r_err_sel;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_slot
    demux_chan_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (w_load[g]),
      .load_data (in_data),
      .out_ready (out_ready[g]),
      .full      (out_valid[g]),
      .data      (out_bus[g*WIDTH +: WIDTH]),
      .can_accept(w_can_accept[g])
    );
  end

endmodule

// File: tb/tb_demux_stream_chan.sv
// tb/tb_demux_stream_chan.sv - scoreboard bench for demux_stream_chan (4- and 3-channel instances)
module tb_demux_stream_chan;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic        in_valid;
  logic        in_bcast;
  logic        in_ready;
  logic [31:0] out_bus;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        err_sel;
  logic [15:0] acc_count;

  logic [7:0]  b_in_data;
  logic [1:0]  b_in_sel;
  logic        b_in_valid;
  logic        b_in_bcast;
  logic        b_in_ready;
  logic [23:0] b_out_bus;
  logic [2:0]  b_out_valid;
  logic [2:0]  b_out_ready;
  logic        b_err_sel;
  logic [15:0] b_acc_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  exp_q [0:3][$];
  logic [7:0]  m_last [0:3];
  logic [15:0] m_cnt;

  demux_stream_chan u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_sel   (in_sel),
    .in_valid (in_valid),
`ifdef DEMUX_STREAM_BROADCAST_EN
    .in_bcast (in_bcast),
`endif
    .in_ready (in_ready),
    .out_bus  (out_bus),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .err_sel  (err_sel),
    .acc_count(acc_count)
  );

  demux_stream_chan #(.CHANNELS(3)) u_dut3 (
    .clk      (clk),
    .rst      (rst),
    .in_data  (b_in_data),
    .in_sel   (b_in_sel),
    .in_valid (b_in_valid),
`ifdef DEMUX_STREAM_BROADCAST_EN
    .in_bcast (b_in_bcast),
`endif
    .in_ready (b_in_ready),
    .out_bus  (b_out_bus),
    .out_valid(b_out_valid),
    .out_ready(b_out_ready),
    .err_sel  (b_err_sel),
    .acc_count(b_acc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the 4-channel instance, evaluated mid-cycle before the next edge.
  always @(negedge clk) begin
    logic [3:0] mv;
    logic       mr;
    logic       bc;
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        exp_q[i].delete();
        m_last[i] = 8'h00;
      end
      m_cnt = 16'h0;
    end else begin
      bc = 1'b0;
`ifdef DEMUX_STREAM_BROADCAST_EN
      bc = in_bcast;
`endif
      for (int i = 0; i < 4; i++) mv[i] = (exp_q[i].size() != 0);
      check("out_valid", out_valid, mv);
      for (int i = 0; i < 4; i++)
        check($sformatf("out_bus[%0d]", i), out_bus[i*8 +: 8], mv[i] ? exp_q[i][0] : m_last[i]);
      check("acc_count", acc_count, m_cnt);
      check("err_sel4", err_sel, 1'b0);
      if (bc) begin
        mr = 1'b1;
        for (int i = 0; i < 4; i++) mr = mr && (!mv[i] || out_ready[i]);
      end else begin
        mr = !mv[in_sel] || out_ready[in_sel];
      end
      check("in_ready", in_ready, mr);
      for (int i = 0; i < 4; i++)
        if (mv[i] && out_ready[i]) void'(exp_q[i].pop_front());
      if (in_valid && mr) begin
        for (int i = 0; i < 4; i++) begin
          if (bc || (in_sel == 2'(i))) begin
            exp_q[i].push_back(in_data);
            m_last[i] = in_data;
          end
        end
        m_cnt = m_cnt + (bc ? 16'd4 : 16'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0; in_bcast = 1'b0; out_ready = '0;
    b_in_data = '0; b_in_sel = '0; b_in_valid = 1'b0; b_in_bcast = 1'b0; b_out_ready = '0;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_valid", out_valid, 4'b0000);
    check("rst_bus", out_bus, 32'h0);
    check("rst_err", err_sel, 1'b0);
    check("rst_cnt", acc_count, 16'h0);
    for (int s = 0; s < 4; s++) begin
      in_sel = 2'(s);
      #1 check($sformatf("rst_ready_sel%0d", s), in_ready, 1'b1);
    end
    step();

    // Routing and backpressure on channel 2
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    #1;
    check("route_valid", out_valid, 4'b0100);
    check("route_bus", out_bus[23:16], 8'hA5);
    check("route_cnt", acc_count, 16'd1);
    in_valid = 1'b1; in_data = 8'h5A;
    #1 check("bp_ready0", in_ready, 1'b0);
    step();
    check("bp_ready1", in_ready, 1'b0);
    out_ready = 4'b0100;
    #1 check("bp_ready2", in_ready, 1'b1);
    step();
    in_valid = 1'b0; out_ready = 4'b0000;
    #1;
    check("popload_valid", out_valid, 4'b0100);
    check("popload_bus", out_bus[23:16], 8'h5A);
    out_ready = 4'b0100;
    step();
    out_ready = 4'b0000;

    // Back-to-back into channel 1
    out_ready = 4'b0010;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1; in_sel = 2'd1; in_data = 8'(k);
      #1 check("b2b_ready", in_ready, 1'b1);
      step();
      check("b2b_bus", out_bus[15:8], 8'(k));
    end
    in_valid = 1'b0;
    #1 check("b2b_cnt", acc_count, 16'd5);
    step();
    out_ready = 4'b0000;

    // Pop slot 0 while loading slot 3
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h11;
    step();
    out_ready = 4'b0001; in_sel = 2'd3; in_data = 8'h3C;
    step();
    in_valid = 1'b0; out_ready = 4'b0000;
    #1;
    check("conc_valid", out_valid, 4'b1000);
    check("conc_bus", out_bus[31:24], 8'h3C);
    check("conc_cnt", acc_count, 16'd7);
    out_ready = 4'b1000;
    step();
    out_ready = 4'b0000;

    // Illegal select on the 3-channel instance
    b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 8'hFF;
    #1 check("ill_ready", b_in_ready, 1'b1);
    step();
    b_in_valid = 1'b0;
    #1;
    check("ill_err", b_err_sel, 1'b1);
    check("ill_valid", b_out_valid, 3'b000);
    check("ill_bus", b_out_bus, 24'h0);
    check("ill_cnt", b_acc_count, 16'h0);
    step();
    check("ill_err_sticky", b_err_sel, 1'b1);
    b_in_valid = 1'b1; b_in_sel = 2'd0; b_in_data = 8'h42;
    step();
    b_in_valid = 1'b0;
    #1;
    check("ill_legal_cnt", b_acc_count, 16'd1);
    check("ill_legal_valid", b_out_valid, 3'b001);
    check("ill_err_kept", b_err_sel, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("ill_err_clr", b_err_sel, 1'b0);
    check("ill_valid_clr", b_out_valid, 3'b000);

    // Randomised traffic, checked by the scoreboard
    for (int c = 0; c < 400; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = 8'($urandom_range(0, 255));
      out_ready = 4'($urandom_range(0, 15));
`ifdef DEMUX_STREAM_BROADCAST_EN
      in_bcast  = ($urandom_range(0, 3) == 0);
`endif
      step();
    end
    in_bcast = 1'b0;

    // Reset mid-stream discards held words and overrides the transfer
    in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h99; out_ready = 4'b0000;
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check("mrst_valid", out_valid, 4'b0000);
    check("mrst_bus", out_bus, 32'h0);
    check("mrst_cnt", acc_count, 16'h0);
    step();

`ifdef DEMUX_STREAM_BROADCAST_EN
    in_bcast = 1'b1; in_valid = 1'b1; in_data = 8'h7E;
    step();
    in_bcast = 1'b0; in_valid = 1'b0;
    #1;
    check("bc_valid", out_valid, 4'b1111);
    check("bc_bus", out_bus, 32'h7E7E7E7E);
    check("bc_cnt", acc_count, 16'd4);
    out_ready = 4'b1101; in_bcast = 1'b1; in_valid = 1'b1; in_data = 8'h81;
    #1 check("bc_block", in_ready, 1'b0);
    step();
    in_bcast = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
    #1 check("bc_block_valid", out_valid, 4'b0010);
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
